// File: rtl/cve2_pkg.sv
// Shared core constants and helpers.
// No timing: package only.
// No flow control: package only.
package cve2_pkg;

    localparam int unsigned RegFileAddrW = 5;

    function automatic int unsigned rf_num_regs(input bit rv32e);
        return rv32e ? 32'd16 : 32'd32;
    endfunction

endpackage

// File: rtl/cve2_rf_wdec.sv
// Register-file write decoder: address plus enable to a one-hot register enable.
// Latency: combinational. Backpressure: none, the enable is always accepted.
module cve2_rf_wdec
    import cve2_pkg::*;
#(
    parameter int unsigned NumRegs = 32
) (
    input  logic [RegFileAddrW-1:0] addr_i,
    input  logic                    we_i,
    output logic [NumRegs-1:0]      en_o
);

    // Bit 0 is never set, and addresses at or above NumRegs match no bit.
    always_comb begin
        en_o = '0;
        for (int unsigned i = 1; i < NumRegs; i++) begin
            en_o[i] = we_i && (addr_i == RegFileAddrW'(i));
        end
    end

endmodule

// File: rtl/cve2_register_file_2w.sv
// Flip-flop GPR file: 2 combinational read ports, 2 write ports (A wins on a tie).
// Latency: reads 0 cycles, writes visible next cycle. Backpressure: none.
module cve2_register_file_2w
    import cve2_pkg::*;
#(
    parameter bit                    RV32E       = 1'b0,
    parameter int unsigned           DataWidth   = 32,
    parameter logic [DataWidth-1:0]  WordZeroVal = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [RegFileAddrW-1:0] raddr_a_i,
    output logic [DataWidth-1:0]    rdata_a_o,
    input  logic [RegFileAddrW-1:0] raddr_b_i,
    output logic [DataWidth-1:0]    rdata_b_o,
    input  logic [RegFileAddrW-1:0] waddr_a_i,
    input  logic [DataWidth-1:0]    wdata_a_i,
    input  logic                    we_a_i,
    input  logic [RegFileAddrW-1:0] waddr_b_i,
    input  logic [DataWidth-1:0]    wdata_b_i,
    input  logic                    we_b_i,
    output logic                    wr_collision_o,
    output logic                    wr_collision_sticky_o
);

    localparam int unsigned NumRegs = rf_num_regs(RV32E);

    logic [NumRegs-1:0]   we_dec_a;
    logic [NumRegs-1:0]   we_dec_b;
    logic [DataWidth-1:0] rf_q [1:NumRegs-1];
    logic [DataWidth-1:0] rf_d [1:NumRegs-1];
    logic                 wr_collision_q, wr_collision_d;
    logic                 wr_collision_sticky_q, wr_collision_sticky_d;

    cve2_rf_wdec #(.NumRegs(NumRegs)) u_wdec_a (
        .addr_i (waddr_a_i),
        .we_i   (we_a_i),
        .en_o   (we_dec_a)
    );

    cve2_rf_wdec #(.NumRegs(NumRegs)) u_wdec_b (
        .addr_i (waddr_b_i),
        .we_i   (we_b_i),
        .en_o   (we_dec_b)
    );

    always_comb begin
        for (int unsigned i = 1; i < NumRegs; i++) begin
            rf_d[i] = rf_q[i];
            if (we_dec_a[i]) begin
                rf_d[i] = wdata_a_i;
            end else if (we_dec_b[i]) begin
                rf_d[i] = wdata_b_i;
            end
        end
    end

    // Decoded enables already exclude x0 and out-of-range addresses.
    always_comb begin
        wr_collision_d        = |(we_dec_a & we_dec_b);
        wr_collision_sticky_d = wr_collision_sticky_q | wr_collision_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 1; i < NumRegs; i++) begin
                rf_q[i] <= WordZeroVal;
            end
            wr_collision_q        <= 1'b0;
            wr_collision_sticky_q <= 1'b0;
        end else begin
            for (int unsigned i = 1; i < NumRegs; i++) begin
                rf_q[i] <= rf_d[i];
            end
            wr_collision_q        <= wr_collision_d;
            wr_collision_sticky_q <= wr_collision_sticky_d;
        end
    end

    always_comb begin
        rdata_a_o = WordZeroVal;
        rdata_b_o = WordZeroVal;
        for (int unsigned i = 1; i < NumRegs; i++) begin
            if (raddr_a_i == RegFileAddrW'(i)) begin
                rdata_a_o = rf_q[i];
            end
            if (raddr_b_i == RegFileAddrW'(i)) begin
                rdata_b_o = rf_q[i];
            end
        end
    end

    assign wr_collision_o        = wr_collision_q;
    assign wr_collision_sticky_o = wr_collision_sticky_q;

`ifndef SYNTHESIS
    we_known_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({we_a_i, we_b_i}));
    coll_implies_sticky_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        wr_collision_o |-> wr_collision_sticky_o);
`endif

endmodule

// File: tb/tb_cve2_register_file_2w.sv
// Bench for cve2_register_file_2w: RV32I instance (0) and RV32E instance (1).
module tb_cve2_register_file_2w;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [2];
    logic [4:0]  raddr_a   [2];
    logic [4:0]  raddr_b   [2];
    logic [31:0] rdata_a   [2];
    logic [31:0] rdata_b   [2];
    logic [4:0]  waddr_a   [2];
    logic [4:0]  waddr_b   [2];
    logic [31:0] wdata_a   [2];
    logic [31:0] wdata_b   [2];
    logic        we_a      [2];
    logic        we_b      [2];
    logic        coll      [2];
    logic        sticky    [2];

    cve2_register_file_2w #(.RV32E(1'b0), .DataWidth(32), .WordZeroVal(32'h0)) u_dut_i (
        .clk_i (clk), .rst_ni (rst_n[0]),
        .raddr_a_i (raddr_a[0]), .rdata_a_o (rdata_a[0]),
        .raddr_b_i (raddr_b[0]), .rdata_b_o (rdata_b[0]),
        .waddr_a_i (waddr_a[0]), .wdata_a_i (wdata_a[0]), .we_a_i (we_a[0]),
        .waddr_b_i (waddr_b[0]), .wdata_b_i (wdata_b[0]), .we_b_i (we_b[0]),
        .wr_collision_o (coll[0]), .wr_collision_sticky_o (sticky[0])
    );

    cve2_register_file_2w #(.RV32E(1'b1), .DataWidth(32), .WordZeroVal(32'h0)) u_dut_e (
        .clk_i (clk), .rst_ni (rst_n[1]),
        .raddr_a_i (raddr_a[1]), .rdata_a_o (rdata_a[1]),
        .raddr_b_i (raddr_b[1]), .rdata_b_o (rdata_b[1]),
        .waddr_a_i (waddr_a[1]), .wdata_a_i (wdata_a[1]), .we_a_i (we_a[1]),
        .waddr_b_i (waddr_b[1]), .wdata_b_i (wdata_b[1]), .we_b_i (we_b[1]),
        .wr_collision_o (coll[1]), .wr_collision_sticky_o (sticky[1])
    );

    // sig: 0 = rdata_a, 1 = rdata_b, 2 = wr_collision, 3 = sticky
    typedef struct {
        string       name;
        int          dut;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] observe(input int d, input int s);
        case (s)
            0:       return rdata_a[d];
            1:       return rdata_b[d];
            2:       return {31'b0, coll[d]};
            default: return {31'b0, sticky[d]};
        endcase
    endfunction

    task automatic expect_v(input string n, input int d, input int s, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.dut  = d;
        e.sig  = s;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d);
        we_a[d] = 1'b0;
        we_b[d] = 1'b0;
    endtask

    // Monitor: compares every queued expectation against the outputs at the falling edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = observe(e.dut, e.sig);
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s dut%0d sig%0d got=%h want=%h", e.name, e.dut, e.sig, act, e.exp);
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d]   = 1'b0;
            raddr_a[d] = '0;
            raddr_b[d] = '0;
            waddr_a[d] = '0;
            waddr_b[d] = '0;
            wdata_a[d] = '0;
            wdata_b[d] = '0;
            we_a[d]    = 1'b0;
            we_b[d]    = 1'b0;
        end
        step();
        step();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Reset state: all 32 addresses read zero, flags clear.
        for (int i = 0; i < 16; i++) begin
            step();
            raddr_a[0] = 5'(i);
            raddr_b[0] = 5'(i + 16);
            expect_v("rst_rd_a", 0, 0, 32'h0);
            expect_v("rst_rd_b", 0, 1, 32'h0);
            expect_v("rst_coll", 0, 2, 32'h0);
            expect_v("rst_sticky", 0, 3, 32'h0);
        end

        // Write x5 with same-cycle read: old value now, new value next cycle.
        step();
        we_a[0] = 1'b1; waddr_a[0] = 5'd5; wdata_a[0] = 32'hDEADBEEF; raddr_a[0] = 5'd5;
        expect_v("no_bypass", 0, 0, 32'h0);
        step();
        idle(0);
        expect_v("x5_after", 0, 0, 32'hDEADBEEF);

        // Dual write to different registers.
        step();
        we_a[0] = 1'b1; waddr_a[0] = 5'd3; wdata_a[0] = 32'h11;
        we_b[0] = 1'b1; waddr_b[0] = 5'd7; wdata_b[0] = 32'h22;
        step();
        idle(0);
        raddr_a[0] = 5'd3; raddr_b[0] = 5'd7;
        expect_v("dual_x3", 0, 0, 32'h11);
        expect_v("dual_x7", 0, 1, 32'h22);
        expect_v("dual_nocoll", 0, 2, 32'h0);
        expect_v("dual_nosticky", 0, 3, 32'h0);

        // Collision on x9: port A wins, one-cycle pulse, sticky stays set.
        step();
        we_a[0] = 1'b1; waddr_a[0] = 5'd9; wdata_a[0] = 32'hAAAA0000;
        we_b[0] = 1'b1; waddr_b[0] = 5'd9; wdata_b[0] = 32'h0000BBBB;
        expect_v("coll_pre", 0, 2, 32'h0);
        step();
        idle(0);
        raddr_a[0] = 5'd9; raddr_b[0] = 5'd5;
        expect_v("coll_x9", 0, 0, 32'hAAAA0000);
        expect_v("coll_x5_kept", 0, 1, 32'hDEADBEEF);
        expect_v("coll_pulse", 0, 2, 32'h1);
        expect_v("coll_sticky", 0, 3, 32'h1);
        step();
        expect_v("coll_pulse_end", 0, 2, 32'h0);
        expect_v("coll_sticky_hold", 0, 3, 32'h1);

        // Both ports write x0: ignored, no collision.
        step();
        we_a[0] = 1'b1; waddr_a[0] = 5'd0; wdata_a[0] = 32'hFFFFFFFF;
        we_b[0] = 1'b1; waddr_b[0] = 5'd0; wdata_b[0] = 32'hFFFFFFFF;
        raddr_a[0] = 5'd0; raddr_b[0] = 5'd0;
        step();
        idle(0);
        expect_v("x0_a", 0, 0, 32'h0);
        expect_v("x0_b", 0, 1, 32'h0);
        expect_v("x0_nocoll", 0, 2, 32'h0);
        step();
        expect_v("x0_nocoll2", 0, 2, 32'h0);
        expect_v("x0_sticky_hold", 0, 3, 32'h1);

        // Reset clears sticky and storage.
        step();
        rst_n[0] = 1'b0;
        raddr_a[0] = 5'd9;
        expect_v("rst2_sticky", 0, 3, 32'h0);
        expect_v("rst2_x9", 0, 0, 32'h0);

        // RV32E: x4 write, then x20 write must not alias onto x4.
        step();
        we_a[1] = 1'b1; waddr_a[1] = 5'd4; wdata_a[1] = 32'h77;
        step();
        we_a[1] = 1'b0;
        we_b[1] = 1'b1; waddr_b[1] = 5'd20; wdata_b[1] = 32'h55;
        raddr_a[1] = 5'd4;
        expect_v("e_x4", 1, 0, 32'h77);
        step();
        idle(1);
        raddr_a[1] = 5'd4; raddr_b[1] = 5'd20;
        expect_v("e_x4_kept", 1, 0, 32'h77);
        expect_v("e_x20_zero", 1, 1, 32'h0);
        expect_v("e_nocoll", 1, 2, 32'h0);
        step();
        #1;
        rst_n[1] = 1'b0;
        expect_v("e_async_rst_x4", 1, 0, 32'h0);
        expect_v("e_async_sticky", 1, 3, 32'h0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            step();
        end
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
